// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath.
//   - Op encoding, matching the control unit's Op field.
//   - State type for the multiply/divide sequencer.
//   - Quotient reported for a divide by zero.
package calc_pkg;

    localparam logic [1:0] OP_ADDSUB = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;
    localparam logic [1:0] OP_DIV    = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [7:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the calculator control unit and mul_div_unit.
//   start       : level request, held until done is seen
//   op          : 01 multiply, 10 divide
//   a, b        : operands (multiplicand/dividend, multiplier/divisor)
//   result      : product, or {remainder, quotient}
//   done / busy : sequencer in DONE / CALC
//   div_by_zero : last divide had b == 0, valid with done
interface mul_div_unit_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] result;
    logic               done;
    logic               busy;
    logic               div_by_zero;

    // control unit side
    modport master (
        output start, op, a, b,
        input  result, done, busy, div_by_zero
    );

    // arithmetic unit side
    modport slave (
        input  start, op, a, b,
        output result, done, busy, div_by_zero
    );
endinterface

// File: rtl/mul_div_step.sv
// One iteration of shift-add multiply or restoring divide (combinational).
//   op      : OP_DIV selects divide, anything else multiply
//   acc_i   : multiply {partial product high, remaining multiplier bits}
//             divide   {partial remainder, dividend/quotient bits}
//   operand : multiplicand (multiply) or divisor (divide)
//   acc_o   : accumulator after this iteration
module mul_div_step
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]         op,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // Carry out of the high-half add lands in the top bit after the shift.
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand} : '0);
        // Remainder shifted left with the next dividend bit; needs WIDTH+1 bits.
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        // rem_sh < 2*divisor, so the MSB of the difference is a clean sign bit.
        trial   = rem_sh - {1'b0, operand};

        if (op == OP_DIV) begin
            if (!trial[WIDTH])
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            else
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential unsigned multiplier / restoring divider, one bit per cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/op/a/b in; result/done/busy/div_by_zero out
// A request is accepted only from IDLE; WIDTH CALC cycles later the result
// is registered and the unit sits in DONE until start is released.
// A divide by zero skips CALC and reports {a, all-ones}.
module mul_div_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] acc_nxt;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc_i   (acc_q),
        .operand (opnd_q),
        .acc_o   (acc_nxt)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        result_d = result_q;
        dz_d     = dz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) begin
                        op_d    = bus.op;
                        count_d = '0;
                        dz_d    = 1'b0;
                        state_d = CALC;
                        // Upper half starts clear; the lower half holds the
                        // bits consumed one per iteration.
                        if (bus.op == OP_MUL) begin
                            acc_d  = {{WIDTH{1'b0}}, bus.b};
                            opnd_d = bus.a;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, bus.a};
                            opnd_d = bus.b;
                        end
                    end else if (bus.op == OP_DIV) begin
                        result_d = {bus.a, WIDTH'(DIV0_QUOTIENT)};
                        dz_d     = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                acc_d   = acc_nxt;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    result_d = acc_nxt;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.done        = (state_q == DONE);
    assign bus.busy        = (state_q == CALC);
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: multiply/divide vectors, divide by zero,
// start handshake (hold, early drop, unsupported op) and reset mid-CALC.
module tb_mul_div_unit;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mul_div_unit_if #(.WIDTH(8)) bus ();

    mul_div_unit #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a request, wait (bounded) for done, check latency, busy cycles,
    // result and div_by_zero. Returns at the negedge where done is first seen,
    // with start still high.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] er, input logic edz,
                         input int elat);
        int lat;
        int bcyc;
        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clock);
        lat = 0; bcyc = 0;
        forever begin
            @(negedge clock);
            if (bus.done) break;
            if (bus.busy) bcyc++;
            lat++;
            if (lat > 40) break;
        end
        chk({tag, "_lat"},  16'(lat),  16'(elat));
        chk({tag, "_busy"}, 16'(bcyc), 16'(elat));
        chk({tag, "_res"},  bus.result, er);
        chk({tag, "_dz"},   16'(bus.div_by_zero), 16'(edz));
    endtask

    // Drop start at a negedge; the next edge returns the unit to IDLE.
    task automatic release_start(input string tag);
        bus.start = 1'b0;
        @(negedge clock);
        chk({tag, "_rel_done"}, 16'(bus.done), 16'h0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_res",  bus.result, 16'h0000);
        chk("rst_done", 16'(bus.done), 16'h0);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_dz",   16'(bus.div_by_zero), 16'h0);
        reset = 1'b0;

        // 13*11, then hold start 5 cycles past done
        do_op("mul13x11", 2'b01, 8'd13, 8'd11, 16'h008F, 1'b0, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_done", 16'(bus.done), 16'h1);
            chk("hold_busy", 16'(bus.busy), 16'h0);
            chk("hold_res",  bus.result, 16'h008F);
        end
        release_start("mul13x11");

        do_op("mul255", 2'b01, 8'd255, 8'd255, 16'hFE01, 1'b0, 8);
        release_start("mul255");
        chk("idle_res_hold", bus.result, 16'hFE01);

        do_op("mul0", 2'b01, 8'd0, 8'd200, 16'h0000, 1'b0, 8);
        release_start("mul0");

        do_op("div200_7", 2'b10, 8'd200, 8'd7, 16'h041C, 1'b0, 8);
        release_start("div200_7");

        // 5/9 with start dropped during CALC: done must be a single-cycle pulse
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'd5; bus.b = 8'd9;
        @(posedge clock);
        repeat (3) @(negedge clock);
        chk("drop_busy", 16'(bus.busy), 16'h1);
        bus.start = 1'b0;
        bus.op = 2'b01; // ignored outside IDLE
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("drop_wait", 16'(n), 16'd6);
        chk("drop_res",  bus.result, 16'h0500);
        @(negedge clock);
        chk("drop_pulse", 16'(bus.done), 16'h0);

        do_op("div0", 2'b10, 8'd100, 8'd0, 16'h64FF, 1'b1, 0);
        release_start("div0");

        // unsupported op: no activity, result held
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'd3; bus.b = 8'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("op00_busy", 16'(bus.busy), 16'h0);
            chk("op00_done", 16'(bus.done), 16'h0);
            chk("op00_res",  bus.result, 16'h64FF);
        end
        bus.start = 1'b0;

        // reset during the 4th CALC cycle
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 8'd13; bus.b = 8'd11;
        @(posedge clock);
        repeat (4) @(negedge clock);
        chk("mid_busy", 16'(bus.busy), 16'h1);
        reset = 1'b1; bus.start = 1'b0;
        @(negedge clock);
        chk("mid_rst_res",  bus.result, 16'h0000);
        chk("mid_rst_done", 16'(bus.done), 16'h0);
        chk("mid_rst_busy", 16'(bus.busy), 16'h0);
        reset = 1'b0;

        do_op("mul_after_rst", 2'b01, 8'd13, 8'd11, 16'h008F, 1'b0, 8);
        release_start("mul_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Sequential 8-bit unsigned multiplier and divider for the four-function calculator. It sits directly downstream of the calculator control unit, which drives its Start and Op inputs and waits on its Done output. The operands come from the A/B operand registers. The result goes to the result register and display path under LoadR. Multiply uses shift-add and divide uses restoring division, each one bit per cycle.

Parameters:
WIDTH, 8, operand width in bits; the iteration count equals WIDTH.

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level request from control unit; held high until done is seen
op  input  2  operation select: 2'b01 multiply, 2'b10 divide; 2'b00 and 2'b11 are not handled here
a  input  WIDTH  multiplicand or dividend, unsigned
b  input  WIDTH  multiplier or divisor, unsigned
result  output  2*WIDTH  multiply: full product; divide: {remainder, quotient}
done  output  1  result valid; high while in DONE
busy  output  1  high while in CALC
div_by_zero  output  1  set when a divide had b==0; valid while done is high

Behaviour:
- Reset:
  - State goes to IDLE.
  - result, done, busy, div_by_zero and count all become 0.
  - Reset wins over every other condition, including in the middle of CALC.
- States: IDLE, CALC, DONE, encoded in 2 bits.
- IDLE:
  - With start=1 and op=01 (MUL), or op=10 (DIV) with b!=0, the unit accepts the request.
    - It latches a, b and op and clears the accumulator and count.
    - div_by_zero is cleared and the state goes to CALC.
  - With start=1, op=10 and b==0:
    - The state goes straight to DONE.
    - result = {a, 8'hFF} and div_by_zero is set.
  - With start=1 and op=00 or op=11, nothing happens; the state stays IDLE and result holds.
- CALC:
  - One iteration is performed per cycle and count increments.
  - Operand inputs are ignored in CALC; only the latched copies are used.
  - Multiply step: if the multiplier LSB is 1, add the multiplicand into the upper half of the 16-bit accumulator with the carry kept, then shift right by 1.
  - Divide step: shift {remainder, quotient} left by 1, then trial-subtract the divisor from the remainder.
    - If the result is non-negative, keep it and set the quotient LSB.
    - Otherwise restore the remainder.
  - On the edge that completes the WIDTH-th iteration, result is registered and the state goes to DONE.
- Latency:
  - Acceptance edge is k. done is first visible after edge k+WIDTH, i.e. k+8.
  - Divide-by-zero: done is first visible after edge k.
- DONE:
  - done=1.
  - The state stays in DONE while start=1, and returns to IDLE on the first edge that samples start=0.
  - If start dropped during CALC, done is high for exactly one cycle.
  - A new request is accepted only from IDLE, so the same level-held start never triggers twice.
- result holds its value after DONE until the next accepted request completes; it is not cleared on return to IDLE.
- busy equals (state==CALC); done equals (state==DONE).
- op changing during CALC or DONE has no effect.
- No overflow can occur: the product fits in 2*WIDTH bits, and quotient and remainder each fit in WIDTH bits.

Decomposition:
- Shared package calc_pkg holds:
  - op encoding constants OP_ADDSUB=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSVD=2'b11, matching the control unit's Op encoding;
  - the state typedef (IDLE/CALC/DONE);
  - DIV0_QUOTIENT = 8'hFF.
- One sub-module, mul_div_step, is natural. It is combinational, one iteration of either algorithm: inputs are op, accumulator and latched operand; output is the next accumulator. The top level keeps the FSM, counter and registers.

Test Plan:
- Multiply 13*11: start=1, op=01, a=13, b=11, held until done. Required: busy for 8 cycles, done after edge k+8, result=16'h008F, div_by_zero=0.
- Multiply corner 255*255: required result=16'hFE01. Then 0*200 gives 16'h0000 with full 8-cycle latency.
- Divide 200/7: required result={8'h04, 8'h1C} (remainder 4, quotient 28) after 8 cycles. Also 5/9 gives {8'h05, 8'h00}.
- Divide by zero 100/0: required done on the cycle after acceptance, result=16'h64FF, div_by_zero=1, busy never high.
- Handshake:
  - Hold start high 5 cycles past done: done stays high, no second operation, result stable.
  - Drop start mid-CALC: done pulses exactly one cycle.
  - Apply op=00 with start=1: stays IDLE, result unchanged.
- Reset mid-operation: assert reset at the 4th CALC cycle. Required: next cycle IDLE with result=0, done=0, busy=0. A following 13*11 then completes correctly.
